// File: rtl/constant_encoder_if.sv
// constant_encoder_if
//   Handshake bundle for constant_encoder.
//   Input side : valid_i / ready_o / data_i   (value to look up)
//   Output side: valid_o / ready_i / hit_o / code_o (lookup result)
//   slave  modport: the encoder itself.
//   master modport: whatever feeds values in and consumes results.
interface constant_encoder_if #(
  parameter int unsigned WORD = 16
);
  logic            valid_i;
  logic            ready_o;
  logic [WORD-1:0] data_i;
  logic            valid_o;
  logic            ready_i;
  logic            hit_o;
  logic [2:0]      code_o;

  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, hit_o, code_o
  );

  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, hit_o, code_o
  );
endinterface

// File: rtl/constant_encoder.sv
// constant_encoder
//   Reverse lookup for the X-Makina constant table: maps a WORD-wide value to
//   the 3-bit constant-select code (0->0, 1->1, 2->2, 3->4, 4->8, 5->16,
//   6->32, 7->all ones) and flags whether any entry matched.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - constant_encoder_if.slave: valid_i/ready_o/data_i in,
//            valid_o/ready_i/hit_o/code_o out
// Configuration macro:
//   CONSTANT_ENCODER_PARALLEL_EN - when defined, all eight entries are
//   compared in the accept cycle (latency 1); otherwise a single comparator
//   walks the table in ascending order, exiting early on a match.
module constant_encoder #(
  parameter int unsigned WORD = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  constant_encoder_if.slave   bus
);

`ifdef CONSTANT_ENCODER_PARALLEL_EN
  typedef enum logic [1:0] {IDLE, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;
`endif

  state_e     state_q, state_d;
  logic       hit_q, hit_d;
  logic [2:0] code_q, code_d;

`ifndef CONSTANT_ENCODER_PARALLEL_EN
  logic [WORD-1:0] data_q, data_d;
  logic [2:0]      idx_q, idx_d;
`endif

  function automatic logic [WORD-1:0] table_value(input logic [2:0] code);
    logic [WORD-1:0] v;
    case (code)
      3'd0:    v = '0;
      3'd1:    v = WORD'(1);
      3'd2:    v = WORD'(2);
      3'd3:    v = WORD'(4);
      3'd4:    v = WORD'(8);
      3'd5:    v = WORD'(16);
      3'd6:    v = WORD'(32);
      default: v = '1;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    code_d  = code_q;
`ifndef CONSTANT_ENCODER_PARALLEL_EN
    data_d  = data_q;
    idx_d   = idx_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
`ifdef CONSTANT_ENCODER_PARALLEL_EN
          // Entries are unique, so at most one comparison can fire.
          hit_d  = 1'b0;
          code_d = '0;
          for (int unsigned i = 0; i < 8; i++) begin
            if (!hit_d && (bus.data_i == table_value(3'(i)))) begin
              hit_d  = 1'b1;
              code_d = 3'(i);
            end
          end
          state_d = DONE;
`else
          data_d  = bus.data_i;
          idx_d   = '0;
          state_d = SEARCH;
`endif
        end
      end
`ifndef CONSTANT_ENCODER_PARALLEL_EN
      SEARCH: begin
        if (data_q == table_value(idx_q)) begin
          hit_d   = 1'b1;
          code_d  = idx_q;
          state_d = DONE;
        end else if (idx_q == 3'd7) begin
          hit_d   = 1'b0;
          code_d  = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
`endif
      DONE: begin
        // Clear the result on consumption so hit/code read 0 outside DONE.
        if (bus.ready_i) begin
          hit_d   = 1'b0;
          code_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      code_q  <= '0;
`ifndef CONSTANT_ENCODER_PARALLEL_EN
      data_q  <= '0;
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      code_q  <= code_d;
`ifndef CONSTANT_ENCODER_PARALLEL_EN
      data_q  <= data_d;
      idx_q   <= idx_d;
`endif
    end
  end

  assign bus.ready_o = (state_q == IDLE);
  assign bus.valid_o = (state_q == DONE);
  assign bus.hit_o   = hit_q;
  assign bus.code_o  = code_q;

endmodule

// File: tb/tb_constant_encoder.sv
module tb_constant_encoder;
  localparam int unsigned WORD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  constant_encoder_if #(.WORD(WORD)) bus ();

  constant_encoder #(.WORD(WORD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [WORD-1:0] data;
    logic            hit;
    logic [2:0]      code;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edges after the accept edge E0 until valid_o is observed.
  function automatic int exp_lat(input logic hit, input logic [2:0] code);
`ifdef CONSTANT_ENCODER_PARALLEL_EN
    return 0;
`else
    return hit ? int'(code) + 1 : 8;
`endif
  endfunction

  // Waits (bounded) for ready_o, then presents one value for one edge.
  task automatic accept(input logic [WORD-1:0] value);
    for (int c = 0; c < 30; c++) begin
      if (bus.ready_o) break;
      @(posedge clk); #1;
    end
    check("accept_ready", 32'(bus.ready_o), 32'd1);
    bus.valid_i = 1'b1;
    bus.data_i  = value;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  // Called at E0+1ns; returns edges elapsed until valid_o seen.
  task automatic wait_valid(output int lat, output logic ok);
    lat = 0;
    ok  = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.valid_o) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int              lat;
    logic            ok;
    int              nres;
    int              sent;
    logic            acc;
    logic            toggle;
    logic            r_hit;
    logic [2:0]      r_code;
    logic [WORD-1:0] stream[3];
    logic            hit_r[3];
    logic [2:0]      code_r[3];

    vecs[0]  = '{16'h0000, 1'b1, 3'd0};
    vecs[1]  = '{16'h0001, 1'b1, 3'd1};
    vecs[2]  = '{16'h0002, 1'b1, 3'd2};
    vecs[3]  = '{16'h0004, 1'b1, 3'd3};
    vecs[4]  = '{16'h0008, 1'b1, 3'd4};
    vecs[5]  = '{16'h0010, 1'b1, 3'd5};
    vecs[6]  = '{16'h0020, 1'b1, 3'd6};
    vecs[7]  = '{16'hFFFF, 1'b1, 3'd7};
    vecs[8]  = '{16'h0003, 1'b0, 3'd0};
    vecs[9]  = '{16'h7FFF, 1'b0, 3'd0};
    vecs[10] = '{16'h0040, 1'b0, 3'd0};

    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.ready_i = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_hit",   32'(bus.hit_o),   32'd0);
    check("reset_code",  32'(bus.code_o),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table sweep with ready_i held high.
    for (int i = 0; i < 11; i++) begin
      accept(vecs[i].data);
      wait_valid(lat, ok);
      check("vec_valid", 32'(ok), 32'd1);
      check("vec_lat", 32'(lat), 32'(exp_lat(vecs[i].hit, vecs[i].code)));
      check("vec_hit", 32'(bus.hit_o), 32'(vecs[i].hit));
      check("vec_code", 32'(bus.code_o), 32'(vecs[i].code));
      @(posedge clk); #1;
      check("vec_valid_one_cycle", 32'(bus.valid_o), 32'd0);
      check("vec_ready_back", 32'(bus.ready_o), 32'd1);
      check("vec_hit_cleared", 32'(bus.hit_o), 32'd0);
    end

    // Reset in the middle of an operation.
    bus.ready_i = 1'b0;
    accept(16'h0020);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_ready_async", 32'(bus.ready_o), 32'd1);
    check("midrst_valid_async", 32'(bus.valid_o), 32'd0);
    @(posedge clk); #1;
    check("midrst_ready", 32'(bus.ready_o), 32'd1);
    check("midrst_valid", 32'(bus.valid_o), 32'd0);
    check("midrst_hit",   32'(bus.hit_o),   32'd0);
    check("midrst_code",  32'(bus.code_o),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    accept(16'h0000);
    wait_valid(lat, ok);
    check("postrst_valid", 32'(ok), 32'd1);
    check("postrst_lat", 32'(lat), 32'(exp_lat(1'b1, 3'd0)));
    check("postrst_hit", 32'(bus.hit_o), 32'd1);
    check("postrst_code", 32'(bus.code_o), 32'd0);
    @(posedge clk); #1;

    // Backpressure: result held while ready_i low.
    bus.ready_i = 1'b0;
    accept(16'h0008);
    wait_valid(lat, ok);
    check("bp_valid", 32'(ok), 32'd1);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(bus.valid_o), 32'd1);
      check("bp_hold_hit",   32'(bus.hit_o),   32'd1);
      check("bp_hold_code",  32'(bus.code_o),  32'd4);
      check("bp_hold_ready", 32'(bus.ready_o), 32'd0);
      @(posedge clk); #1;
    end
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_consumed_valid", 32'(bus.valid_o), 32'd0);
    check("bp_consumed_ready", 32'(bus.ready_o), 32'd1);
    check("bp_consumed_code",  32'(bus.code_o),  32'd0);

    // Input isolation: data_i/valid_i wiggle after acceptance.
    accept(16'h0010);
    nres   = 0;
    toggle = 1'b1;
    r_hit  = 1'b0;
    r_code = '0;
    for (int c = 0; c < 20; c++) begin
      if (bus.valid_o) begin
        if (nres == 0) begin
          r_hit  = bus.hit_o;
          r_code = bus.code_o;
        end
        nres++;
        toggle = 1'b0;
      end
      bus.data_i = '0;
      if (toggle) bus.valid_i = ~bus.valid_i;
      else        bus.valid_i = 1'b0;
      @(posedge clk); #1;
    end
    check("iso_results", 32'(nres), 32'd1);
    check("iso_hit", 32'(r_hit), 32'd1);
    check("iso_code", 32'(r_code), 32'd5);

    // valid_i presented while a result is pending is ignored.
    bus.ready_i = 1'b0;
    accept(16'h0001);
    wait_valid(lat, ok);
    check("done_valid", 32'(ok), 32'd1);
    bus.valid_i = 1'b1;
    bus.data_i  = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("done_ready_low", 32'(bus.ready_o), 32'd0);
      check("done_hold_code", 32'(bus.code_o), 32'd1);
      check("done_hold_hit",  32'(bus.hit_o),  32'd1);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(posedge clk); #1;
    check("done_consumed_valid", 32'(bus.valid_o), 32'd0);
    @(posedge clk); #1;
    check("done_not_accepted", 32'(bus.ready_o), 32'd1);
    check("done_no_result", 32'(bus.valid_o), 32'd0);

    // Back-to-back stream with valid_i held high.
    stream[0] = 16'h0001;
    stream[1] = 16'hFFFF;
    stream[2] = 16'h0005;
    hit_r[0] = 1'b0; hit_r[1] = 1'b0; hit_r[2] = 1'b0;
    code_r[0] = '0;  code_r[1] = '0;  code_r[2] = '0;
    nres = 0;
    sent = 0;
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = stream[0];
    for (int c = 0; c < 60; c++) begin
      acc = bus.ready_o && bus.valid_i;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 3) bus.data_i = stream[sent];
        else          bus.valid_i = 1'b0;
      end
      if (bus.valid_o) begin
        if (nres < 3) begin
          hit_r[nres]  = bus.hit_o;
          code_r[nres] = bus.code_o;
        end
        nres++;
      end
    end
    check("b2b_sent", 32'(sent), 32'd3);
    check("b2b_results", 32'(nres), 32'd3);
    check("b2b_hit0",  32'(hit_r[0]),  32'd1);
    check("b2b_code0", 32'(code_r[0]), 32'd1);
    check("b2b_hit1",  32'(hit_r[1]),  32'd1);
    check("b2b_code1", 32'(code_r[1]), 32'd7);
    check("b2b_hit2",  32'(hit_r[2]),  32'd0);
    check("b2b_code2", 32'(code_r[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
